mod_sub_pipe: RTL

- Pipelined modular subtractor; computes (iData0 - iData1) mod iQ. It is the inverse operation of the team's modular adder.
- Used in NTT/RNS butterflies on the difference leg, next to the adder.
- Two register stages with valid/ready flow control and full backpressure. Sustains one result per cycle.

---
 rtl/mod_sub_pipe.sv | 67 ++++++
 1 files changed

// File: rtl/mod_sub_pipe.sv
`default_nettype none
// ============================================================================
// mod_sub_pipe : two-stage pipelined (a - b) mod q with valid/ready handshake
// Revision 1.0 : initial release
// ============================================================================
module mod_sub_pipe #(
    parameter int BITWIDTH = 32
) (
    input  logic                iClk,
    input  logic                iRstN,
    input  logic                iValid,
    output logic                oReady,
    input  logic [BITWIDTH-1:0] iData0,
    input  logic [BITWIDTH-1:0] iData1,
    input  logic [BITWIDTH-1:0] iQ,
    output logic                oValid,
    input  logic                iReady,
    output logic [BITWIDTH-1:0] oData
);

    logic [BITWIDTH:0]   d1;
    logic [BITWIDTH-1:0] q1;
    logic                v1;
    logic                v2;

    logic                en1;
    logic                en2;
    logic                in_xfer;
    logic [BITWIDTH:0]   diff_next;
    logic [BITWIDTH-1:0] res_next;

    assign en2       = !v2 || iReady;
    assign en1       = !v1 || en2;
    assign oReady    = en1 && iRstN;
    assign in_xfer   = iValid && oReady;
    assign oValid    = v2;

    // MSB of the extended difference is the borrow out of the subtraction.
    assign diff_next = {1'b0, iData0} - {1'b0, iData1};
    assign res_next  = d1[BITWIDTH] ? (d1[BITWIDTH-1:0] + q1) : d1[BITWIDTH-1:0];

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            d1    <= '0;
            q1    <= '0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            oData <= '0;
        end else begin
            if (en2) begin
                v2 <= v1;
                if (v1) begin
                    oData <= res_next;
                end
            end
            if (en1) begin
                v1 <= in_xfer;
                if (in_xfer) begin
                    d1 <= diff_next;
                    q1 <= iQ;
                end
            end
        end
    end

endmodule
`default_nettype wire
